hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the enable/flush pair of the IF/ID and ID/EX pipeline registers and the PC enable. It sits beside the ID and EX stages. It inspects the instruction in ID against the instruction in EX, then issues load-use bubbles, taken-branch flushes and multi-cycle mul/div holds. It is the control end of the pipeline-register enable/flush interface.

## Interface
Parameters:
- MULDIV_CYCLES, 32, number of cycles a mul/div instruction occupies EX (legal range 1..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_MR  in  1  EX instruction is a load.
- ex_is_muldiv  in  1  EX instruction is mul/div.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register flush.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX register flush.
- md_busy  out  1  a mul/div is being held in EX.
- stall_cycles  out  CNT_W  cycles with pc_en=0 (perf).
- flush_count  out  CNT_W  taken-branch flushes (perf).

## Operation
- Registered state is FSM {RUN, MD_BUSY} plus an 8-bit down-counter md_cnt.
- Outputs are combinational from state and inputs.
- Default in RUN with no hazard: pc_en=if_id_en=id_ex_en=1, both flushes 0, md_busy=0.
- Priority is rst > mul/div hold > branch flush > load-use.
- Mul/div in RUN:
  - Condition: ex_is_muldiv=1 and MULDIV_CYCLES>1.
  - Outputs: pc_en=if_id_en=id_ex_en=0, md_busy=1.
  - Next state: MD_BUSY with md_cnt=MULDIV_CYCLES-2.
- MD_BUSY, md_cnt≠0: same hold outputs; md_cnt decrements.
- MD_BUSY, md_cnt=0: release cycle. Default outputs, md_busy=1, next state RUN. Total EX occupancy is exactly MULDIV_CYCLES cycles.
- MULDIV_CYCLES=1: mul/div never stalls and the FSM stays in RUN.
- ex_branch_taken and the load-use check are ignored in MD_BUSY.
- Branch flush (RUN, ex_branch_taken=1): pc_en=1, if_id_flush=1, id_ex_flush=1, enables 1.
- Load-use:
  - Condition: ex_MR=1, ex_rd≠0, and (id_uses_rs1 with id_rs1=ex_rd, or id_uses_rs2 with id_rs2=ex_rd).
  - Outputs: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, which inserts one bubble.
  - The hazard clears on the next cycle because EX then holds the bubble.
- Register x0 never creates a hazard.

## Timing
- Decision latency is 0 cycles: outputs respond in the same cycle as the inputs.
- FSM and counters update on posedge clk.
- Outputs while rst=1: pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=1, md_busy=0.
- State after reset: RUN, md_cnt=0, stall_cycles=0, flush_count=0.
- Reset mid-mul/div: the FSM is in RUN on the first cycle after rst deasserts, and the counter is discarded.
- A load-use stall costs exactly 1 cycle. A taken branch costs 2 squashed instructions and no stall cycle.
- Perf counters:
  - stall_cycles increments on each non-reset cycle with pc_en=0.
  - flush_count increments on each cycle where a branch flush is issued.
  - Both saturate at 2^CNT_W−1 and do not wrap.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles and flush_count are implemented as specified.
- Not defined: both outputs are tied to 0 and no counter flops are built. FSM and hazard behaviour are identical in both builds.

## Test plan
- Load-use: ex_MR=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. With ex_rd=0 -> no stall.
- Mul/div, MULDIV_CYCLES=4: ex_is_muldiv=1 held -> 3 cycles with id_ex_en=0, then a release cycle with id_ex_en=1 and md_busy=1, then RUN. stall_cycles=3.
- Branch: ex_branch_taken=1 for 1 cycle -> if_id_flush=id_ex_flush=1, pc_en=1, flush_count 0→1. Branch plus load-use in the same cycle -> flush wins and there is no stall.
- Reset mid-hold: rst asserted in the 2nd MD_BUSY cycle -> reset outputs while rst=1, RUN with all enables 1 on the next cycle, counters 0.
- MULDIV_CYCLES=1: ex_is_muldiv=1 -> no stall, md_busy stays 0.
- Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cycles sticks at 15. With HAZARD_PERF_EN undefined -> the counter reads 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller <-> pipeline register interface
//
// Groups the ID/EX instruction fields the hazard controller inspects with the
// enable/flush controls it drives into the PC and pipeline registers.
//   master : hazard controller side (reads ID/EX fields, drives enables/flushes)
//   slave  : pipeline side (supplies ID/EX fields, consumes enables/flushes)
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_MR;
    logic       ex_is_muldiv;
    logic       ex_branch_taken;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_MR, ex_is_muldiv, ex_branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_MR, ex_is_muldiv, ex_branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (load-use, branch flush, mul/div hold)
//
// Purpose: compares the ID instruction against the EX instruction and drives
// the PC enable and the IF/ID, ID/EX enable/flush pairs. Outputs are
// combinational from state and inputs (zero decision latency).
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   hz             hazard_ctrl_if.master: ID/EX fields in, enables/flushes out
//   md_busy_o      a mul/div is being held in EX (includes release cycle)
//   stall_cycles_o cycles with pc_en=0 (saturating perf counter)
//   flush_count_o  taken-branch flushes issued (saturating perf counter)
// Configuration: define HAZARD_PERF_EN to build the perf counters; otherwise
// both counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_if.master     hz,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    typedef enum logic [0:0] {RUN, MD_BUSY} state_t;

    // The RUN-state hold cycle is the first of MULDIV_CYCLES, and the release
    // cycle is the last, so the counter covers the MULDIV_CYCLES-2 in between.
    localparam bit         MD_STALLS = (MULDIV_CYCLES > 1);
    localparam int         MD_LOAD_I = MD_STALLS ? (MULDIV_CYCLES - 2) : 0;
    localparam logic [7:0] MD_LOAD   = MD_LOAD_I[7:0];

    state_t     state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;

    logic load_use;
    logic md_start;
    logic branch_flush;

    always_comb begin
        load_use = hz.ex_MR && (hz.ex_rd != 5'd0) &&
                   ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
        md_start = MD_STALLS && hz.ex_is_muldiv;
    end

    always_comb begin
        hz.pc_en       = 1'b1;
        hz.if_id_en    = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_en    = 1'b1;
        hz.id_ex_flush = 1'b0;
        md_busy_o      = 1'b0;
        branch_flush   = 1'b0;
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;

        if (rst) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_en    = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            state_d        = RUN;
            md_cnt_d       = 8'd0;
        end else if (state_q == MD_BUSY) begin
            // Branch and load-use inputs are ignored while the mul/div owns EX.
            md_busy_o = 1'b1;
            if (md_cnt_q != 8'd0) begin
                hz.pc_en    = 1'b0;
                hz.if_id_en = 1'b0;
                hz.id_ex_en = 1'b0;
                md_cnt_d    = md_cnt_q - 8'd1;
            end else begin
                state_d = RUN;
            end
        end else if (md_start) begin
            hz.pc_en    = 1'b0;
            hz.if_id_en = 1'b0;
            hz.id_ex_en = 1'b0;
            md_busy_o   = 1'b1;
            state_d     = MD_BUSY;
            md_cnt_d    = MD_LOAD;
        end else if (hz.ex_branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            branch_flush   = 1'b1;
        end else if (load_use) begin
            // Freeze PC and IF/ID, let ID/EX load a bubble.
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        md_cnt_q <= md_cnt_d;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!hz.pc_en && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (branch_flush && (flush_count_q != '1))
                flush_count_q <= flush_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    logic       md_busy_a, md_busy_b;
    logic [3:0] stall_a, flush_a, stall_b, flush_b;

    assign ifb.id_rs1          = ifa.id_rs1;
    assign ifb.id_rs2          = ifa.id_rs2;
    assign ifb.id_uses_rs1     = ifa.id_uses_rs1;
    assign ifb.id_uses_rs2     = ifa.id_uses_rs2;
    assign ifb.ex_rd           = ifa.ex_rd;
    assign ifb.ex_MR           = ifa.ex_MR;
    assign ifb.ex_is_muldiv    = ifa.ex_is_muldiv;
    assign ifb.ex_branch_taken = ifa.ex_branch_taken;

    hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa),
        .md_busy_o(md_busy_a), .stall_cycles_o(stall_a), .flush_count_o(flush_a)
    );

    hazard_ctrl #(.MULDIV_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb),
        .md_busy_o(md_busy_b), .stall_cycles_o(stall_b), .flush_count_o(flush_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic md, input logic br);
        ifa.id_rs1          = rs1;
        ifa.id_rs2          = rs2;
        ifa.id_uses_rs1     = u1;
        ifa.id_uses_rs2     = u2;
        ifa.ex_rd           = rd;
        ifa.ex_MR           = mr;
        ifa.ex_is_muldiv    = md;
        ifa.ex_branch_taken = br;
        #1;
    endtask

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_busy}
    function automatic logic [5:0] ctl_a();
        return {ifa.pc_en, ifa.if_id_en, ifa.if_id_flush, ifa.id_ex_en, ifa.id_ex_flush, md_busy_a};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {ifb.pc_en, ifb.if_id_en, ifb.if_id_flush, ifb.id_ex_en, ifb.id_ex_flush, md_busy_b};
    endfunction

    localparam logic [5:0] C_RUN   = 6'b110100;
    localparam logic [5:0] C_RST   = 6'b001010;
    localparam logic [5:0] C_LU    = 6'b000110;
    localparam logic [5:0] C_BR    = 6'b111110;
    localparam logic [5:0] C_HOLD  = 6'b000001;
    localparam logic [5:0] C_REL   = 6'b110101;

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("reset_outputs", 32'(ctl_a()), 32'(C_RST));
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_run", 32'(ctl_a()), 32'(C_RUN));
        check("idle_stall_cnt", 32'(stall_a), 32'd0);
        check("idle_flush_cnt", 32'(flush_a), 32'd0);

        // load-use on rs1: one bubble
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        check("lu_rs1", 32'(ctl_a()), 32'(C_LU));
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_clears", 32'(ctl_a()), 32'(C_RUN));
        check("lu_stall_cnt", 32'(stall_a), PERF ? 32'd1 : 32'd0);

        // x0 never hazards
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("lu_x0", 32'(ctl_a()), 32'(C_RUN));
        // match on rs2 but rs2 not used
        drive(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        check("lu_rs2_unused", 32'(ctl_a()), 32'(C_RUN));
        // non-load producer
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        check("lu_not_load", 32'(ctl_a()), 32'(C_RUN));
        // load-use on rs2
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("lu_rs2", 32'(ctl_a()), 32'(C_LU));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu2_stall_cnt", 32'(stall_a), PERF ? 32'd2 : 32'd0);

        // taken branch
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("branch", 32'(ctl_a()), 32'(C_BR));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("branch_flush_cnt", 32'(flush_a), PERF ? 32'd1 : 32'd0);
        // branch beats load-use
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        check("branch_over_lu", 32'(ctl_a()), 32'(C_BR));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("branch2_flush_cnt", 32'(flush_a), PERF ? 32'd2 : 32'd0);
        check("branch2_stall_cnt", 32'(stall_a), PERF ? 32'd2 : 32'd0);

        // mul/div, 4 cycles: 3 holds + release
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("md_hold0", 32'(ctl_a()), 32'(C_HOLD));
        check("md1_no_stall", 32'(ctl_b()), 32'(C_RUN));
        tick();
        // branch and load-use must be ignored while busy
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
        check("md_hold1", 32'(ctl_a()), 32'(C_HOLD));
        tick();
        check("md_hold2", 32'(ctl_a()), 32'(C_HOLD));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("md_release", 32'(ctl_a()), 32'(C_REL));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("md_back_run", 32'(ctl_a()), 32'(C_RUN));
        check("md_stall_cnt", 32'(stall_a), PERF ? 32'd5 : 32'd0);
        check("md_flush_cnt", 32'(flush_a), PERF ? 32'd2 : 32'd0);

        // reset during the 2nd MD_BUSY cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("rmd_busy1", 32'(ctl_a()), 32'(C_HOLD));
        tick();
        rst = 1'b1;
        #1;
        check("rmd_reset_out", 32'(ctl_a()), 32'(C_RST));
        tick();
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rmd_run", 32'(ctl_a()), 32'(C_RUN));
        check("rmd_stall_cnt", 32'(stall_a), 32'd0);
        check("rmd_flush_cnt", 32'(flush_a), 32'd0);

        // 20-cycle stall saturates a 4-bit counter at 15
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_pc_en", 32'(ifa.pc_en), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sat_stall_cnt", 32'(stall_a), PERF ? 32'd15 : 32'd0);
        tick();
        check("sat_stall_hold", 32'(stall_a), PERF ? 32'd15 : 32'd0);
        check("sat_md1_busy", 32'(md_busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
